// File: rtl/esn_pkg.sv
// Shared types and constants for the ESN step sequencer.
// FSM states, delay-line control word and float coefficients.
package esn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BIAS,
    S_IN,
    S_RES,
    S_DRAIN,
    S_WAIT,
    S_LEAK,
    S_WB,
    S_OUT,
    S_ODRAIN,
    S_YV,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_BIAS,
    PH_IN,
    PH_RES,
    PH_LEAK,
    PH_OUT
  } phase_t;

  localparam int IDX_W = 16;

  typedef struct packed {
    phase_t           phase;
    logic             last;
    logic [IDX_W-1:0] addr;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    phase: PH_NONE,
    last:  1'b0,
    addr:  '0
  };

  localparam logic [31:0] A_COEF  = 32'h3E99999A;
  localparam logic [31:0] A1_COEF = 32'h3F333333;
  localparam logic [31:0] WOUTB   = 32'hBECC6D1F;

endpackage

// File: rtl/esn_ctrl_delay.sv
// Aligns issued control words with the data returned by the heap.
// Full words to the enable tap; a leak flag runs to the X2 tap.
module esn_ctrl_delay
  import esn_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int EN_TAP = 1
) (
  input  logic  clk,
  input  logic  nrst,
  input  ctrl_t din,
  output ctrl_t en_tap,
  output logic  x2_hit
);

  ctrl_t [EN_TAP:0] q;
  logic  [DEPTH-1:0] lk;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q  <= '0;
      lk <= '0;
    end else begin
      q  <= {q[EN_TAP-1:0], din};
      lk <= {lk[DEPTH-2:0], din.phase == PH_LEAK};
    end
  end

  assign en_tap = q[EN_TAP];
  assign x2_hit = lk[DEPTH-1];

endmodule

// File: rtl/esn_step_sequencer.sv
// Control FSM for one echo-state-network step over the MAC datapath.
// Optional cycle counter output cyc_cnt under ESN_PERF_CNT_EN.
module esn_step_sequencer
  import esn_pkg::*;
#(
  parameter int N_RES  = 16,
  parameter int N_IN   = 1,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              act_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] winb_addr,
  output logic [ADDR_W-1:0] win_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] wout_addr,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic [ADDR_W-1:0] x_wr_addr,
  output logic              x_we,
  output logic              en_x1_n,
  output logic              en_x2_n,
  output logic              en_w_n,
  output logic              en_win_n,
  output logic              en_winb_n,
  output logic              en_wout_n,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              act_start,
  output logic              y_valid
`ifdef ESN_PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IN  = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_RES = ADDR_W'(N_RES - 1);
  localparam logic [ADDR_W-1:0] LAST_DR  = ADDR_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] N_IN_A   = ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0] N_RES_A  = ADDR_W'(N_RES);

  state_t state, nxt;
  logic [ADDR_W-1:0] row, cnt;
  logic [ADDR_W-2:0] in_xa;
  logic bank;
  ctrl_t push, tap;
  logic x2_hit;

  assign in_xa = (ADDR_W-1)'(N_RES) + cnt[ADDR_W-2:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      row       <= '0;
      cnt       <= '0;
      bank      <= 1'b0;
      act_start <= 1'b0;
    end else begin
      state     <= nxt;
      act_start <= (state == S_DRAIN) && (nxt == S_WAIT);
      cnt       <= (state != nxt) ? '0 : cnt + 1'b1;
      if (state == S_IDLE)
        row <= '0;
      else if (state == S_WB && nxt == S_BIAS)
        row <= row + 1'b1;
      if (state == S_DONE)
        bank <= ~bank;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_BIAS;
      S_BIAS:   nxt = S_IN;
      S_IN:     if (cnt == LAST_IN) nxt = S_RES;
      S_RES:    if (cnt == LAST_RES) nxt = S_DRAIN;
      S_DRAIN:  if (cnt == LAST_DR) nxt = S_WAIT;
      S_WAIT:   if (act_done) nxt = S_LEAK;
      S_LEAK:   nxt = S_WB;
      // leave only once the leaky term has been written back
      S_WB:     if (x2_hit)
                  nxt = (row == LAST_RES) ? S_OUT : S_BIAS;
      S_OUT:    if (cnt == LAST_RES) nxt = S_ODRAIN;
      S_ODRAIN: if (cnt == LAST_DR) nxt = S_YV;
      S_YV:     nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    winb_addr = '0;
    win_addr  = '0;
    w_addr    = '0;
    wout_addr = '0;
    x_rd_addr = '0;
    push      = CTRL_NONE;
    unique case (state)
      S_BIAS: begin
        winb_addr = row;
        push = '{phase: PH_BIAS, last: 1'b0,
                 addr: IDX_W'(row)};
      end
      S_IN: begin
        win_addr  = row * N_IN_A + cnt;
        x_rd_addr = {bank, in_xa};
        push = '{phase: PH_IN, last: 1'b0,
                 addr: IDX_W'(cnt)};
      end
      S_RES: begin
        w_addr    = row * N_RES_A + cnt;
        x_rd_addr = {bank, cnt[ADDR_W-2:0]};
        push = '{phase: PH_RES,
                 last: cnt == LAST_RES,
                 addr: IDX_W'(cnt)};
      end
      S_LEAK: begin
        x_rd_addr = {bank, row[ADDR_W-2:0]};
        push = '{phase: PH_LEAK, last: 1'b0,
                 addr: IDX_W'(row)};
      end
      S_OUT: begin
        wout_addr = cnt;
        x_rd_addr = {~bank, cnt[ADDR_W-2:0]};
        push = '{phase: PH_OUT,
                 last: cnt == LAST_RES,
                 addr: IDX_W'(cnt)};
      end
      default: ;
    endcase
  end

  esn_ctrl_delay #(
    .DEPTH  (RD_LAT + 3),
    .EN_TAP (RD_LAT)
  ) u_delay (
    .clk    (clk),
    .nrst   (nrst),
    .din    (push),
    .en_tap (tap),
    .x2_hit (x2_hit)
  );

  always_comb begin
    en_winb_n = !(tap.phase == PH_BIAS);
    en_win_n  = !(tap.phase == PH_IN);
    en_w_n    = !(tap.phase == PH_RES);
    en_wout_n = !(tap.phase == PH_OUT);
    en_x1_n   = !(tap.phase == PH_IN ||
                  tap.phase == PH_RES ||
                  tap.phase == PH_OUT);
    en_x2_n   = !x2_hit;
    acc_clr   = (tap.phase == PH_BIAS) ||
                (tap.phase == PH_OUT && tap.addr == '0);
    acc_last  = (tap.phase == PH_RES ||
                 tap.phase == PH_OUT) && tap.last;
    x_we      = x2_hit;
    x_wr_addr = x2_hit ? {~bank, row[ADDR_W-2:0]} : '0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    y_valid   = (state == S_YV);
  end

`ifdef ESN_PERF_CNT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      if (state == S_IDLE)
        run_cnt <= 32'd1;
      else if (run_cnt != '1)
        run_cnt <= run_cnt + 32'd1;
      if (state == S_DONE)
        cyc_cnt <= run_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_esn_step_sequencer.sv
// Self-checking bench for esn_step_sequencer (N_RES=4, N_IN=1, RD_LAT=1).
// Scoreboard of expected heap terms plus reset/idle vector table.
module tb_esn_step_sequencer;

  localparam int N_RES  = 4;
  localparam int N_IN   = 1;
  localparam int AW     = 10;
  localparam int RD_LAT = 1;
  localparam int ACT_DLY = 3;
  localparam int ROW_CYC = 1 + N_IN + N_RES + (RD_LAT + 1)
                         + (ACT_DLY + 1) + 1 + (RD_LAT + 3);
  localparam int EXP_TOTAL = 1 + N_RES * ROW_CYC + N_RES
                           + (RD_LAT + 1) + 1;

  localparam int K_BIAS = 0;
  localparam int K_IN   = 1;
  localparam int K_RES  = 2;
  localparam int K_LEAK = 3;
  localparam int K_OUT  = 4;

  logic clk = 0;
  logic nrst = 0;
  logic start = 0;
  logic act_r = 0;
  logic spur_ad = 0;
  logic busy, done, x_we, acc_clr, acc_last, act_start, y_valid;
  logic en_x1_n, en_x2_n, en_w_n, en_win_n, en_winb_n, en_wout_n;
  logic [AW-1:0] winb_addr, win_addr, w_addr, wout_addr;
  logic [AW-1:0] x_rd_addr, x_wr_addr;
`ifdef ESN_PERF_CNT_EN
  logic [31:0] cyc_cnt;
`endif

  esn_step_sequencer #(
    .N_RES(N_RES), .N_IN(N_IN), .ADDR_W(AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .act_done(act_r | spur_ad),
    .busy(busy), .done(done),
    .winb_addr(winb_addr), .win_addr(win_addr),
    .w_addr(w_addr), .wout_addr(wout_addr),
    .x_rd_addr(x_rd_addr), .x_wr_addr(x_wr_addr),
    .x_we(x_we),
    .en_x1_n(en_x1_n), .en_x2_n(en_x2_n), .en_w_n(en_w_n),
    .en_win_n(en_win_n), .en_winb_n(en_winb_n),
    .en_wout_n(en_wout_n),
    .acc_clr(acc_clr), .acc_last(acc_last),
    .act_start(act_start), .y_valid(y_valid)
`ifdef ESN_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xwe_cnt = 0;
  int yv_cnt = 0;
  bit mon_en = 0;

  typedef struct packed {
    logic [AW-1:0] winb, win, w, wout, xrd, xwr;
    logic xwe, clr, last, yv;
    logic nwinb, nwin, nw, nwout, nx1, nx2;
  } snap_t;

  typedef struct {
    int kind;
    logic [AW-1:0] waddr;
    logic [AW-1:0] xaddr;
    logic clr;
    logic last;
  } exp_t;

  typedef struct {
    logic nrst;
    logic start;
    logic [12:0] st;
  } vec_t;

  snap_t hist [0:7];
  exp_t sb[$];
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] stat();
    return {busy, done, x_we, acc_clr, acc_last, act_start,
            y_valid, en_winb_n, en_win_n, en_w_n, en_wout_n,
            en_x1_n, en_x2_n};
  endfunction

  function automatic logic [AW-1:0] xa(input logic b, input int v);
    logic [AW-2:0] lo;
    lo = v[AW-2:0];
    return {b, lo};
  endfunction

  function automatic snap_t cur();
    snap_t s;
    s.winb = winb_addr; s.win = win_addr;
    s.w = w_addr; s.wout = wout_addr;
    s.xrd = x_rd_addr; s.xwr = x_wr_addr;
    s.xwe = x_we; s.clr = acc_clr; s.last = acc_last;
    s.yv = y_valid;
    s.nwinb = en_winb_n; s.nwin = en_win_n; s.nw = en_w_n;
    s.nwout = en_wout_n; s.nx1 = en_x1_n; s.nx2 = en_x2_n;
    return s;
  endfunction

  // Every heap term retiring is matched against the next expected term.
  task automatic mon_step();
    snap_t h, a;
    exp_t e;
    int nlow, kind;
    logic [AW-1:0] wa;
    h = hist[0];
    a = hist[RD_LAT+1];
    nlow = int'(!h.nwinb) + int'(!h.nwin) + int'(!h.nw)
         + int'(!h.nwout) + int'(!h.nx2);
    if (h.xwe) xwe_cnt++;
    if (h.yv) yv_cnt++;
    if (done) chk("done_after_yv", 32'(hist[1].yv), 1);
    if (nlow > 1) begin
      chk("single_enable", nlow, 1);
    end else if (nlow == 1) begin
      kind = !h.nwinb ? K_BIAS : !h.nwin ? K_IN :
             !h.nw ? K_RES : !h.nwout ? K_OUT : K_LEAK;
      if (sb.size() == 0) begin
        chk("unexpected_term", kind, 32'hFF);
      end else begin
        e = sb.pop_front();
        chk("term_kind", kind, e.kind);
        chk("en_x1", 32'(h.nx1),
            32'(kind == K_BIAS || kind == K_LEAK));
        chk("acc_clr", 32'(h.clr), 32'(e.clr));
        chk("acc_last", 32'(h.last), 32'(e.last));
        if (kind == K_LEAK) begin
          chk("x2_rd_addr", hist[RD_LAT+3].xrd, e.xaddr);
          chk("x_we", 32'(h.xwe), 1);
          chk("x_wr_addr", h.xwr, e.waddr);
        end else begin
          wa = (kind == K_BIAS) ? a.winb :
               (kind == K_IN) ? a.win :
               (kind == K_RES) ? a.w : a.wout;
          chk("weight_addr", wa, e.waddr);
          if (kind != K_BIAS)
            chk("x1_rd_addr", a.xrd, e.xaddr);
        end
      end
    end else if (h.xwe) begin
      chk("stray_x_we", 32'(h.xwe), 0);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 7; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = cur();
    if (mon_en) mon_step();
  end

  // Activation unit model: result valid ACT_DLY cycles after act_start.
  initial begin
    int pend;
    pend = 0;
    forever begin
      @(posedge clk); #1;
      act_r = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) act_r = 1;
      end
      if (act_start) pend = ACT_DLY;
    end
  end

  task automatic push_step(input logic b);
    for (int i = 0; i < N_RES; i++) begin
      sb.push_back('{K_BIAS, AW'(i), '0, 1'b1, 1'b0});
      for (int j = 0; j < N_IN; j++)
        sb.push_back('{K_IN, AW'(i * N_IN + j),
                       xa(b, N_RES + j), 1'b0, 1'b0});
      for (int k = 0; k < N_RES; k++)
        sb.push_back('{K_RES, AW'(i * N_RES + k),
                       xa(b, k), 1'b0, k == N_RES - 1});
      sb.push_back('{K_LEAK, xa(~b, i), xa(b, i), 1'b0, 1'b0});
    end
    for (int k = 0; k < N_RES; k++)
      sb.push_back('{K_OUT, AW'(k), xa(~b, k),
                     k == 0, k == N_RES - 1});
  endtask

  task automatic run_step(input logic b, input bit hold,
                          input bit spur);
    int n, busy_cyc;
    bit seen;
    push_step(b);
    xwe_cnt = 0;
    yv_cnt = 0;
    seen = 0;
    n = 0;
    @(posedge clk); #1;
    start = 1;
    while (!seen && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (!hold) start = 0;
      spur_ad = spur && (n == 4);
      if (done) seen = 1;
    end
    start = 0;
    spur_ad = 0;
    chk("done_seen", 32'(seen), 1);
    chk("step_cycles", n, EXP_TOTAL);
    chk("x_we_count", xwe_cnt, N_RES);
    chk("y_valid_count", yv_cnt, 1);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 0);
`ifdef ESN_PERF_CNT_EN
    chk("cyc_cnt", cyc_cnt, EXP_TOTAL);
`endif
    busy_cyc = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
    end
    chk("no_restart", busy_cyc, 0);
  endtask

  initial begin
    int we_seen;
    vt[0] = '{1'b0, 1'b0, 13'b0000000_111111};
    vt[1] = '{1'b0, 1'b1, 13'b0000000_111111};
    vt[2] = '{1'b1, 1'b0, 13'b0000000_111111};
    vt[3] = '{1'b1, 1'b1, 13'b1000000_111111};

    #2;
    for (int v = 0; v < 4; v++) begin
      nrst = vt[v].nrst;
      start = vt[v].start;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_status", v), 32'(stat()),
          32'(vt[v].st));
      chk($sformatf("vec%0d_addr0", v),
          32'(|{winb_addr, win_addr, w_addr, wout_addr,
                x_rd_addr, x_wr_addr}), 0);
    end
    start = 0;

    // Abort in the middle of the recurrent sum.
    repeat (3) @(posedge clk);
    #1;
    nrst = 0;
    #1;
    chk("abort_status", 32'(stat()), 32'(vt[0].st));
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
    we_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (x_we || busy) we_seen++;
    end
    chk("abort_quiet", we_seen, 0);

    mon_en = 1;
    run_step(1'b0, 1'b0, 1'b0);
    run_step(1'b1, 1'b1, 1'b1);
    mon_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
